// File: rtl/add3_pkg.sv
// Shared definitions for the 3-bit-slice word sequencer.
//
// Contents:
//   SLICE_W   - width of one adder slice chunk (3 bits)
//   state_t   - sequencer FSM states (IDLE, RUN, DONE)
//   idx_width - width of the chunk index counter for a given chunk count
package add3_pkg;

  localparam int SLICE_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ceil(log2(n)), but never narrower than one bit.
  function automatic int idx_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/add3_word_sequencer.sv
// add3_word_sequencer
//
// Purpose: drives an external combinational 3-bit ripple adder slice one
// chunk per cycle (LSB chunk first) to add two W-bit operands plus a carry-in,
// chaining each chunk's carry-out into the next chunk's carry-in.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. The producer holds data stable while valid is high and
// ready is low; ready never depends combinationally on valid.
//
// Ports:
//   clk, rst              - clock (rising edge), synchronous active-high reset
//   in_valid/in_ready     - operand handshake; in_ready is high only in IDLE
//   in_a, in_b, in_cin    - W-bit operands and initial carry (W = 3*NUM_SLICES)
//   slc_a, slc_b, slc_cin - current chunk and carry to the slice (0 outside RUN)
//   slc_s, slc_cout       - slice sum chunk and carry-out
//   out_valid/out_ready   - result handshake; out_valid is high only in DONE
//   out_sum, out_cout     - W-bit sum and final carry, held until next DONE
//   out_ovf               - signed overflow (only with ADD3_SEQ_OVF_EN)
//   dbg_state             - current FSM state (state_t encoding)
//
// Optional feature: define ADD3_SEQ_OVF_EN to add the out_ovf output.
module add3_word_sequencer
  import add3_pkg::*;
#(
  parameter int NUM_SLICES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SLICE_W*NUM_SLICES-1:0] in_a,
  input  logic [SLICE_W*NUM_SLICES-1:0] in_b,
  input  logic                          in_cin,
  output logic [SLICE_W-1:0]            slc_a,
  output logic [SLICE_W-1:0]            slc_b,
  output logic                          slc_cin,
  input  logic [SLICE_W-1:0]            slc_s,
  input  logic                          slc_cout,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SLICE_W*NUM_SLICES-1:0] out_sum,
  output logic                          out_cout,
`ifdef ADD3_SEQ_OVF_EN
  output logic                          out_ovf,
`endif
  output logic [1:0]                    dbg_state
);

  localparam int W    = SLICE_W * NUM_SLICES;
  localparam int IDXW = idx_width(NUM_SLICES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_SLICES - 1);

  state_t            state, state_nx;
  logic [IDXW-1:0]   idx, idx_nx;
  logic [W-1:0]      a_r, a_nx;
  logic [W-1:0]      b_r, b_nx;
  logic              carry_r, carry_nx;
  // acc_r collects chunk sums during RUN; sum_r is the published result and
  // only changes when a whole operation completes.
  logic [W-1:0]      acc_r, acc_nx;
  logic [W-1:0]      sum_r, sum_nx;
  logic              cout_r, cout_nx;
  logic [SLICE_W-1:0] chunk_a, chunk_b;
`ifdef ADD3_SEQ_OVF_EN
  logic              ovf_r, ovf_nx;
`endif

  // Chunk selection by compare-and-pick keeps every part-select constant.
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int i = 0; i < NUM_SLICES; i++) begin
      if (idx == IDXW'(i)) begin
        chunk_a = a_r[i*SLICE_W +: SLICE_W];
        chunk_b = b_r[i*SLICE_W +: SLICE_W];
      end
    end
  end

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    a_nx      = a_r;
    b_nx      = b_r;
    carry_nx  = carry_r;
    acc_nx    = acc_r;
    sum_nx    = sum_r;
    cout_nx   = cout_r;
`ifdef ADD3_SEQ_OVF_EN
    ovf_nx    = ovf_r;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    slc_a     = '0;
    slc_b     = '0;
    slc_cin   = 1'b0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_nx     = in_a;
          b_nx     = in_b;
          carry_nx = in_cin;
          idx_nx   = '0;
          state_nx = RUN;
        end
      end

      RUN: begin
        slc_a    = chunk_a;
        slc_b    = chunk_b;
        slc_cin  = carry_r;
        carry_nx = slc_cout;
        for (int i = 0; i < NUM_SLICES; i++) begin
          if (idx == IDXW'(i)) acc_nx[i*SLICE_W +: SLICE_W] = slc_s;
        end
        if (idx == LAST_IDX) begin
          state_nx = DONE;
          idx_nx   = '0;
          sum_nx   = acc_nx;
          cout_nx  = slc_cout;
`ifdef ADD3_SEQ_OVF_EN
          // Carry into the MSB is a^b^sum at the top bit; overflow when it
          // differs from the carry out of the MSB.
          ovf_nx   = a_r[W-1] ^ b_r[W-1] ^ slc_s[SLICE_W-1] ^ slc_cout;
`endif
        end else begin
          idx_nx = idx + IDXW'(1);
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      acc_r   <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
`ifdef ADD3_SEQ_OVF_EN
      ovf_r   <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      a_r     <= a_nx;
      b_r     <= b_nx;
      carry_r <= carry_nx;
      acc_r   <= acc_nx;
      sum_r   <= sum_nx;
      cout_r  <= cout_nx;
`ifdef ADD3_SEQ_OVF_EN
      ovf_r   <= ovf_nx;
`endif
    end
  end

  assign out_sum   = sum_r;
  assign out_cout  = cout_r;
`ifdef ADD3_SEQ_OVF_EN
  assign out_ovf   = ovf_r;
`endif
  assign dbg_state = state;

endmodule

// File: tb/tb_add3_word_sequencer.sv
// Testbench for add3_word_sequencer paired with a gate-level model of the
// 3-bit ripple adder slice. Directed steps plus a random sweep; results are
// checked against a scoreboard of reference sums.
module tb_add3_word_sequencer;

  localparam int NS = 4;
  localparam int W  = 3 * NS;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready, in_cin;
  logic [W-1:0]   in_a, in_b, out_sum;
  logic [2:0]     slc_a, slc_b, slc_s;
  logic           slc_cin, slc_cout;
  logic           out_valid, out_ready, out_cout;
  logic [1:0]     dbg_state;
`ifdef ADD3_SEQ_OVF_EN
  logic           out_ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [W+1:0] exp_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- 3-bit ripple slice model ----------------
  logic c1, c2;
  assign slc_s[0] = slc_a[0] ^ slc_b[0] ^ slc_cin;
  assign c1       = (slc_a[0] & slc_b[0]) | (slc_cin & (slc_a[0] ^ slc_b[0]));
  assign slc_s[1] = slc_a[1] ^ slc_b[1] ^ c1;
  assign c2       = (slc_a[1] & slc_b[1]) | (c1 & (slc_a[1] ^ slc_b[1]));
  assign slc_s[2] = slc_a[2] ^ slc_b[2] ^ c2;
  assign slc_cout = (slc_a[2] & slc_b[2]) | (c2 & (slc_a[2] ^ slc_b[2]));

  add3_word_sequencer #(.NUM_SLICES(NS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .slc_a(slc_a), .slc_b(slc_b), .slc_cin(slc_cin),
    .slc_s(slc_s), .slc_cout(slc_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
`ifdef ADD3_SEQ_OVF_EN
    .out_ovf(out_ovf),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- helpers / drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] obs_word();
    logic ovf;
`ifdef ADD3_SEQ_OVF_EN
    ovf = out_ovf;
`else
    ovf = 1'b0;
`endif
    return 64'({ovf, out_cout, out_sum});
  endfunction

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W:0] s;
    logic       ovf;
    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
`ifdef ADD3_SEQ_OVF_EN
    ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
`else
    ovf = 1'b0;
`endif
    exp_q.push_back({ovf, s});
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int guard;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk("accept_ready", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    push_exp(a, b, cin);
  endtask

  // Step through RUN, recording slc_cin per chunk, until out_valid appears.
  task automatic run_slices(output logic [15:0] cins);
    int lat;
    lat  = 0;
    cins = '0;
    while (!out_valid && lat < 40) begin
      if (lat < 16) cins[lat] = slc_cin;
      tick();
      lat++;
    end
    chk("latency", 64'(lat), 64'(NS));
  endtask

  task automatic take(input string tag);
    logic [W+1:0] e;
    chk("queue_nonempty", 64'(exp_q.size() != 0), 64'(1));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk(tag, obs_word(), 64'(e));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [15:0]  cins;
    logic [W+1:0] e;
    logic [63:0]  held;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    do_reset();

    // Reset state
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_result",    obs_word(),     64'(0));
    chk("rst_slc",       64'({slc_a, slc_b, slc_cin}), 64'(0));
    chk("rst_state",     64'(dbg_state), 64'(0));

    // 0x123 + 0x456
    send(12'h123, 12'h456, 1'b0);
    run_slices(cins);
    chk("basic_sum_direct", 64'(out_sum), 64'(12'h579));
    take("basic_sum");
    chk("basic_valid_drop", 64'(out_valid), 64'(0));

    // All ones + cin ripples carry through every chunk
    send(12'hFFF, 12'h000, 1'b1);
    run_slices(cins);
    chk("ripple_cins", 64'(cins[3:0]), 64'(4'b1111));
    chk("ripple_cout", 64'(out_cout), 64'(1));
    take("ripple_sum");

    // Output stall with in_valid asserted meanwhile
    send(12'h0AB, 12'h0CD, 1'b0);
    run_slices(cins);
    held = obs_word();
    in_a = 12'h111; in_b = 12'h222; in_cin = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_valid",  64'(out_valid), 64'(1));
      chk("stall_ready",  64'(in_ready),  64'(0));
      chk("stall_stable", obs_word(),     held);
    end
    e = exp_q.pop_front();
    chk("stall_sum", obs_word(), 64'(e));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_hs_valid", 64'(out_valid), 64'(0));
    chk("post_hs_ready", 64'(in_ready),  64'(1));
    push_exp(12'h111, 12'h222, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("post_hs_taken", 64'(dbg_state), 64'(1));
    run_slices(cins);
    take("after_stall_sum");

    // Reset during RUN at idx=2 (out_ready high throughout has no effect)
    out_ready = 1'b1;
    send(12'h555, 12'h333, 1'b0);
    tick();
    tick();
    chk("mid_run_chunk2", 64'(slc_a), 64'(3'h5));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    void'(exp_q.pop_back());
    chk("abort_in_ready",  64'(in_ready),  64'(1));
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_slc",       64'({slc_a, slc_b, slc_cin}), 64'(0));
    chk("abort_result",    obs_word(),     64'(0));
    send(12'h001, 12'h001, 1'b0);
    run_slices(cins);
    take("after_abort_sum");

    // Reset in DONE with out_ready low
    send(12'h700, 12'h900, 1'b0);
    run_slices(cins);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(exp_q.pop_back());
    chk("done_abort_valid",  64'(out_valid), 64'(0));
    chk("done_abort_result", obs_word(),     64'(0));

    // Back-to-back with in_valid held high
    out_ready = 1'b1;
    in_a = 12'h0F0; in_b = 12'h10F; in_cin = 1'b1; in_valid = 1'b1;
    push_exp(12'h0F0, 12'h10F, 1'b1);
    tick();
    in_a = 12'hABC; in_b = 12'h654; in_cin = 1'b0;
    run_slices(cins);
    e = exp_q.pop_front();
    chk("b2b_first", obs_word(), 64'(e));
    tick();
    chk("b2b_idle_ready", 64'(in_ready),  64'(1));
    chk("b2b_valid_drop", 64'(out_valid), 64'(0));
    push_exp(12'hABC, 12'h654, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("b2b_second_taken", 64'(dbg_state), 64'(1));
    run_slices(cins);
    take("b2b_second");
    out_ready = 1'b0;

`ifdef ADD3_SEQ_OVF_EN
    send(12'h7FF, 12'h001, 1'b0);
    run_slices(cins);
    chk("ovf_pos", 64'(out_ovf), 64'(1));
    take("ovf_pos_word");
    send(12'h800, 12'h7FF, 1'b0);
    run_slices(cins);
    chk("ovf_none", 64'(out_ovf), 64'(0));
    chk("ovf_none_sum", 64'(out_sum), 64'(12'hFFF));
    take("ovf_none_word");
`endif

    // Random sweep with occasional output stalls
    for (int n = 0; n < 1000; n++) begin
      send(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)),
           1'($urandom_range(0, 1)));
      run_slices(cins);
      for (int s = $urandom_range(0, 2); s > 0; s--) tick();
      take("rand_sum");
    end

    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
